// File: rtl/demux_1to8_deser_pkg.sv
// Shared constants for the 8-lane serial link: lane count, select width and
// lane indices, common to this deserialiser and the transmit-side 8:1 mux counter.
package demux_1to8_deser_pkg;

    localparam int N_LANES = 8;
    localparam int SEL_W   = 3;

    localparam logic [SEL_W-1:0] LANE0 = 3'b000;
    localparam logic [SEL_W-1:0] LANE1 = 3'b001;
    localparam logic [SEL_W-1:0] LANE2 = 3'b010;
    localparam logic [SEL_W-1:0] LANE3 = 3'b011;
    localparam logic [SEL_W-1:0] LANE4 = 3'b100;
    localparam logic [SEL_W-1:0] LANE5 = 3'b101;
    localparam logic [SEL_W-1:0] LANE6 = 3'b110;
    localparam logic [SEL_W-1:0] LANE7 = 3'b111;

endpackage

// File: rtl/demux_1to8_deser_sel_counter.sv
// Lane select counter: wraps 7->0 on inc, with clear and load-1 for frame restart,
// plus a terminal flag while pointing at the last lane.
module demux_1to8_deser_sel_counter
    import demux_1to8_deser_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    input  logic             load1_i,
    output logic [SEL_W-1:0] cnt_o,
    output logic             term_o
);

    logic [SEL_W-1:0] cnt_q;
    logic [SEL_W-1:0] cnt_d;

    // NOTE: the default assignment first keeps every path through always_comb
    // assigned, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load1_i) begin
            cnt_d = LANE1;
        end else if (clr_i) begin
            cnt_d = LANE0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= LANE0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == LANE7);

endmodule

// File: rtl/demux_1to8_deser.sv
// 1:8 serial-to-parallel deserialiser: routes each accepted bit to the lane named
// by the select counter and hands completed words out through a valid/ready register.
module demux_1to8_deser
    import demux_1to8_deser_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_valid,
    input  logic               sync,
    output logic [N_LANES-1:0] dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [SEL_W-1:0]   sel,
    output logic               overrun,
    input  logic               ovr_clr
);

    // Lane 7 never needs storage: it goes straight into the candidate word.
    logic [N_LANES-2:0] shadow_q, shadow_d;
    logic [N_LANES-1:0] dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               overrun_q, overrun_d;

    logic [SEL_W-1:0]   sel_q;
    logic               sel_term;
    logic               beat;
    logic               complete;
    logic               ovr_event;
    logic [N_LANES-1:0] candidate;

    assign beat      = din_valid && !sync;
    assign complete  = beat && sel_term;
    assign candidate = {din, shadow_q};

    demux_1to8_deser_sel_counter u_sel_counter (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (beat),
        .clr_i   (sync),
        .load1_i (sync && din_valid),
        .cnt_o   (sel_q),
        .term_o  (sel_term)
    );

    always_comb begin
        shadow_d = shadow_q;
        if (sync) begin
            shadow_d = '0;
            if (din_valid) begin
                shadow_d[0] = din;
            end
        end else if (beat && !sel_term) begin
            shadow_d[sel_q] = din;
        end
    end

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        ovr_event    = 1'b0;
        if (complete) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = candidate;
                dout_valid_d = 1'b1;
            end else begin
                ovr_event = 1'b1;
            end
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    // Set beats clear so a drop coinciding with ovr_clr is never lost.
    always_comb begin
        overrun_d = overrun_q;
        if (ovr_clr) begin
            overrun_d = 1'b0;
        end
        if (ovr_event) begin
            overrun_d = 1'b1;
        end
    end

    // NOTE: the shadow and output word are plain registers, not a memory, so they
    // take the async reset; a reset mid-word must leave no stale bits behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign sel        = sel_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_demux_1to8_deser.sv
// Directed bench for demux_1to8_deser: hand-computed words, handshake, overrun,
// sync restart and asynchronous reset.
module tb_demux_1to8_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       sync;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [2:0] sel;
    logic       overrun;
    logic       ovr_clr;

    int passed = 0;
    int total  = 0;

    demux_1to8_deser dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sync       (sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .sel        (sel),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Sends bits first..last of w; bit k is expected on lane k.
    task automatic send_bits(input logic [7:0] w, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            din       = w[k];
            din_valid = 1'b1;
            check($sformatf("sel_before_lane%0d", k), {5'b0, sel}, 8'(k));
            tick();
        end
        din_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; sync = 1'b0;
        dout_ready = 1'b1; ovr_clr = 1'b0;
        repeat (2) tick();
        check("rst_sel", {5'b0, sel}, 8'h00);
        check("rst_dout", dout, 8'h00);
        check("rst_valid", {7'b0, dout_valid}, 8'h00);
        check("rst_overrun", {7'b0, overrun}, 8'h00);
        rst = 1'b0;

        // 1: back-to-back beats, 1,0,1,1,0,0,1,0 -> 8'h4D
        send_bits(8'h4D, 0, 7);
        check("t1_dout", dout, 8'h4D);
        check("t1_valid", {7'b0, dout_valid}, 8'h01);
        check("t1_sel_wrap", {5'b0, sel}, 8'h00);
        tick();
        check("t1_valid_one_cycle", {7'b0, dout_valid}, 8'h00);

        // 2: beats on alternate cycles, sel holds in the gaps
        w = 8'h4D;
        for (int k = 0; k < 8; k++) begin
            din = w[k];
            din_valid = 1'b1;
            tick();
            din_valid = 1'b0;
            if (k < 7) begin
                check($sformatf("t2_gap_sel%0d", k), {5'b0, sel}, 8'(k + 1));
                tick();
                check($sformatf("t2_gap_hold%0d", k), {5'b0, sel}, 8'(k + 1));
            end
        end
        check("t2_dout", dout, 8'h4D);
        check("t2_valid", {7'b0, dout_valid}, 8'h01);
        tick();
        check("t2_drained", {7'b0, dout_valid}, 8'h00);

        // 3: consumer stalled across two words -> first kept, overrun set
        dout_ready = 1'b0;
        send_bits(8'hA5, 0, 7);
        check("t3_first", dout, 8'hA5);
        check("t3_no_ovr_yet", {7'b0, overrun}, 8'h00);
        send_bits(8'h3C, 0, 7);
        check("t3_dout_kept", dout, 8'hA5);
        check("t3_valid", {7'b0, dout_valid}, 8'h01);
        check("t3_overrun", {7'b0, overrun}, 8'h01);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("t3_ovr_cleared", {7'b0, overrun}, 8'h00);
        check("t3_dout_after_clr", dout, 8'hA5);
        dout_ready = 1'b1;
        tick();
        check("t3_drained", {7'b0, dout_valid}, 8'h00);

        // 4: consumer accepts in the same cycle word 2 completes
        dout_ready = 1'b0;
        send_bits(8'hA5, 0, 7);
        send_bits(8'hFF, 0, 6);
        check("t4_hold_valid", {7'b0, dout_valid}, 8'h01);
        check("t4_hold_dout", dout, 8'hA5);
        dout_ready = 1'b1;
        send_bits(8'hFF, 7, 7);
        check("t4_dout", dout, 8'hFF);
        check("t4_valid_cont", {7'b0, dout_valid}, 8'h01);
        check("t4_no_overrun", {7'b0, overrun}, 8'h00);
        tick();
        check("t4_drained", {7'b0, dout_valid}, 8'h00);

        // 5: partial word then sync carrying lane 0 -> 8'h0F, no word from partial
        send_bits(8'h1A, 0, 4);
        check("t5_sel_partial", {5'b0, sel}, 8'h05);
        sync = 1'b1; din = 1'b1; din_valid = 1'b1;
        tick();
        sync = 1'b0; din_valid = 1'b0;
        check("t5_sel_after_sync", {5'b0, sel}, 8'h01);
        check("t5_no_word", {7'b0, dout_valid}, 8'h00);
        send_bits(8'h0F, 1, 7);
        check("t5_dout", dout, 8'h0F);
        check("t5_valid", {7'b0, dout_valid}, 8'h01);
        tick();
        // sync alone clears sel to lane 0
        send_bits(8'h07, 0, 2);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        check("t5_sync_only_sel", {5'b0, sel}, 8'h00);
        check("t5_sync_only_valid", {7'b0, dout_valid}, 8'h00);

        // 6: async reset mid-word, then mid-hold with overrun set
        send_bits(8'h0B, 0, 3);
        check("t6_sel_mid", {5'b0, sel}, 8'h04);
        rst = 1'b1;
        #1;
        check("t6_rst_sel", {5'b0, sel}, 8'h00);
        rst = 1'b0;
        dout_ready = 1'b0;
        send_bits(8'h5A, 0, 7);
        send_bits(8'h81, 0, 7);
        check("t6_hold_overrun", {7'b0, overrun}, 8'h01);
        check("t6_hold_dout", dout, 8'h5A);
        send_bits(8'h00, 0, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", {7'b0, dout_valid}, 8'h00);
        check("t6_rst_dout", dout, 8'h00);
        check("t6_rst_overrun", {7'b0, overrun}, 8'h00);
        check("t6_rst_sel2", {5'b0, sel}, 8'h00);
        rst = 1'b0;
        dout_ready = 1'b1;
        send_bits(8'hC3, 0, 7);
        check("t6_fresh_dout", dout, 8'hC3);
        check("t6_fresh_valid", {7'b0, dout_valid}, 8'h01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
